imem_loader: RTL and testbench

Serial writer for the instruction memory that the CPU's PC-driven fetch port reads. It receives a program image over a UART line, assembles big-endian 32-bit words, and writes them to consecutive word addresses through a write port (we/addr/data). It holds the CPU in reset until the image is fully loaded, so the fetch side starts at address 0 with valid contents.

---
 rtl/imem_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Loads a program image received over a UART line into the instruction memory
// through a simple write port. The CPU is held in reset until the whole image
// has been written, so the fetch side starts at word 0 with valid contents.
//
// Image format (big-endian):
//   LEN_HI LEN_LO  -- 16-bit word count N (0 .. 2**ADDR_W)
//   N x 4 bytes    -- one word each, first byte lands in wdata[31:24]
//   [CHK]          -- XOR of every preceding byte (only with the checksum build)
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN -- when defined, a trailing checksum byte is
//   expected and checked; a mismatch ends in the error state.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   ADDR_W        word-address width of the instruction memory
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   uart_rx  in   asynchronous 8N1 serial input, LSB first, idle high
//   we       out  one-cycle write strobe
//   waddr    out  word address of the write
//   wdata    out  word to write
//   busy     out  transfer in progress (first length byte .. done/error)
//   done     out  image loaded, sticky until rst
//   err      out  framing/length/checksum error, sticky until rst
//   cpu_rst  out  CPU reset, released only when done rises
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Largest legal word count; one more than the highest address.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit_idx;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             byte_vld;
  logic             frame_err;
  logic             rx_sample;
  logic             rx_fall;

  // rx_prev is only for edge detection; the receiver itself works on rx_sync.
  assign rx_fall = rx_prev & ~rx_sync;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // it unassigned and infer a latch.
    rx_state_nxt = rx_state;
    rx_sample    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check: a line already back high was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_sample    = 1'b1;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_sample = 1'b1;
          if (rx_bit_idx == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop lets a back-to-back start bit be caught.
        if (rx_cnt == BIT_LAST) begin
          rx_sample    = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_vld   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_nxt;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
      else                                  rx_cnt <= rx_cnt + 1'b1;

      if (rx_sample) begin
        case (rx_state)
          RX_START: rx_bit_idx <= '0;
          RX_DATA: begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_idx <= rx_bit_idx + 1'b1;
          end
          RX_STOP: begin
            if (rx_sync) begin
              byte_vld <= 1'b1;
              rx_byte  <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LD_LEN_HI,
    LD_LEN_LO,
    LD_WORD,
    LD_CHK,
    LD_DONE,
    LD_ERROR
  } ld_state_t;
  localparam ld_state_t LD_AFTER_LAST = LD_CHK;
`else
  typedef enum logic [2:0] {
    LD_LEN_HI,
    LD_LEN_LO,
    LD_WORD,
    LD_DONE,
    LD_ERROR
  } ld_state_t;
  localparam ld_state_t LD_AFTER_LAST = LD_DONE;
`endif

  ld_state_t   ld_state, ld_state_nxt;
  logic [7:0]  len_hi;
  logic [16:0] n_words;
  logic [16:0] len_req;
  logic [1:0]  byte_idx;
  logic        we_nxt;
  logic        busy_nxt;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk;
`endif

  assign len_req   = {1'b0, len_hi, rx_byte};
  // Evaluated during the we cycle: is this the final word of the image?
  assign last_word = (17'(waddr) + 17'd1) == n_words;

  always_comb begin
    ld_state_nxt = ld_state;
    we_nxt       = 1'b0;
    case (ld_state)
      LD_LEN_HI: begin
        if (frame_err)     ld_state_nxt = LD_ERROR;
        else if (byte_vld) ld_state_nxt = LD_LEN_LO;
      end
      LD_LEN_LO: begin
        if (frame_err) begin
          ld_state_nxt = LD_ERROR;
        end else if (byte_vld) begin
          if (len_req > MAX_WORDS)  ld_state_nxt = LD_ERROR;
          else if (len_req == '0)   ld_state_nxt = LD_AFTER_LAST;
          else                      ld_state_nxt = LD_WORD;
        end
      end
      LD_WORD: begin
        if (frame_err) begin
          ld_state_nxt = LD_ERROR;
        end else if (we) begin
          if (last_word) ld_state_nxt = LD_AFTER_LAST;
        end else if (byte_vld && byte_idx == 2'd3) begin
          we_nxt = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHK: begin
        if (frame_err)     ld_state_nxt = LD_ERROR;
        else if (byte_vld) ld_state_nxt = (rx_byte == chk) ? LD_DONE : LD_ERROR;
      end
`endif
      default: ;  // DONE and ERROR are terminal until rst
    endcase

    busy_nxt = (ld_state_nxt == LD_LEN_LO) || (ld_state_nxt == LD_WORD)
`ifdef IMEM_LOADER_CHECKSUM_EN
            || (ld_state_nxt == LD_CHK)
`endif
            ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state <= LD_LEN_HI;
      len_hi   <= '0;
      n_words  <= '0;
      byte_idx <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      ld_state <= ld_state_nxt;
      we       <= we_nxt;

      // Holding the address after the final word keeps it from wrapping
      // when the image fills the whole memory.
      if (we && !last_word) waddr <= waddr + 1'b1;

      if (byte_vld) begin
        case (ld_state)
          LD_LEN_HI: len_hi  <= rx_byte;
          LD_LEN_LO: n_words <= len_req;
          LD_WORD: begin
            wdata    <= {wdata[23:0], rx_byte};
            byte_idx <= byte_idx + 1'b1;
          end
          default: ;
        endcase
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (byte_vld && (ld_state == LD_LEN_HI || ld_state == LD_LEN_LO ||
                       ld_state == LD_WORD))
        chk <= chk ^ rx_byte;
`endif

      // Status outputs are flops decoded from the next state.
      busy    <= busy_nxt;
      done    <= (ld_state_nxt == LD_DONE);
      err     <= (ld_state_nxt == LD_ERROR);
      cpu_rst <= (ld_state_nxt != LD_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader with CLKS_PER_BIT=16 and ADDR_W=8. A monitor
// logs every write strobe and the cycles where done rises / cpu_rst falls;
// the main sequence sends UART frames and compares against hand-derived values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       we;
  logic [7:0] waddr;
  logic [31:0] wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic       cpu_rst;

  int vectors     = 0;
  int miscompares = 0;

  imem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .uart_rx(uart_rx),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .cpu_rst(cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write / status monitor, sampled on the falling edge.
  int          cyc          = 0;
  int          wr_n         = 0;
  int          last_we_cyc  = 0;
  int          done_rise_cyc = 0;
  int          rst_fall_cyc  = 0;
  bit          done_q       = 1'b0;
  bit          cpu_rst_q    = 1'b0;
  logic [7:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = waddr;
        wr_data[wr_n] = wdata;
      end
      wr_n        = wr_n + 1;
      last_we_cyc = cyc;
    end
    if (done === 1'b1 && !done_q)    done_rise_cyc = cyc;
    if (cpu_rst === 1'b0 && cpu_rst_q) rst_fall_cyc = cyc;
    done_q    = (done === 1'b1);
    cpu_rst_q = (cpu_rst === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] tb_chk;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int idle_cyc);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (idle_cyc) @(negedge clk);
    tb_chk = tb_chk ^ b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tb_chk = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  int         base;
  logic [7:0] c;

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    tb_chk  = 8'h00;

    // ---- Reset values ----------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_we",      32'(we),      32'd0);
    check("rst_waddr",   32'(waddr),   32'd0);
    check("rst_wdata",   wdata,        32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Two-word load, mostly back-to-back bytes --------------------------
    base = wr_n;
    send_byte(8'h00, 1'b1, 4);
    check("load_busy_after_len_hi", 32'(busy), 32'd1);
    check("load_cpu_rst_busy",      32'(cpu_rst), 32'd1);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h20, 1'b1, 0);
    send_byte(8'h08, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h05, 1'b1, 0);
    send_byte(8'hAC, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h04, 1'b1, 8);
    check("load_not_done_before_chk", 32'(done), 32'd0);
    c = tb_chk;  // 0x85 for this image
    send_byte(c, 1'b1, 8);
`else
    send_byte(8'h04, 1'b1, 8);
    check("load_done_cycle",    32'(done_rise_cyc), 32'(last_we_cyc + 1));
    check("load_cpu_rst_cycle", 32'(rst_fall_cyc),  32'(last_we_cyc + 1));
`endif
    check("load_we_count", 32'(wr_n - base), 32'd2);
    check("load_addr0",    32'(wr_addr[base]),     32'd0);
    check("load_data0",    wr_data[base],          32'h2008_0005);
    check("load_addr1",    32'(wr_addr[base + 1]), 32'd1);
    check("load_data1",    wr_data[base + 1],      32'hAC02_0004);
    check("load_done",     32'(done),    32'd1);
    check("load_cpu_rst",  32'(cpu_rst), 32'd0);
    check("load_busy",     32'(busy),    32'd0);
    check("load_err",      32'(err),     32'd0);

    // Bytes after DONE are ignored.
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 8);
    check("done_ignore_we",   32'(wr_n - base), 32'd2);
    check("done_ignore_done", 32'(done),        32'd1);

    // ---- Framing error on the 3rd byte -----------------------------------
    do_reset();
    check("frm_cpu_rst_after_rst", 32'(cpu_rst), 32'd1);
    check("frm_done_after_rst",    32'(done),    32'd0);
    base = wr_n;
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h02, 1'b1, 4);
    send_byte(8'h20, 1'b0, 8);
    check("frm_err",     32'(err),     32'd1);
    check("frm_busy",    32'(busy),    32'd0);
    check("frm_cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h08, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h05, 1'b1, 0);
    send_byte(8'hAC, 1'b1, 8);
    check("frm_no_we",   32'(wr_n - base), 32'd0);
    check("frm_err_sticky", 32'(err),  32'd1);
    check("frm_no_done", 32'(done),    32'd0);

    // ---- Glitch, then oversize length ------------------------------------
    do_reset();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_err",  32'(err),  32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h01, 1'b1, 8);
    check("oversize_err",     32'(err),     32'd1);
    check("oversize_busy",    32'(busy),    32'd0);
    check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);

    // ---- Reset in the middle of word 0, then reload -------------------------
    do_reset();
    base = wr_n;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 8);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    do_reset();
    check("mid_waddr_after_rst",   32'(waddr),   32'd0);
    check("mid_busy_after_rst",    32'(busy),    32'd0);
    check("mid_cpu_rst_after_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 0);
    send_byte(8'hBE, 1'b1, 0);
    send_byte(8'hEF, 1'b1, 8);
`ifdef IMEM_LOADER_CHECKSUM_EN
    c = tb_chk;  // 0x23 for this image
    send_byte(c, 1'b1, 8);
`endif
    check("mid_we_count", 32'(wr_n - base),    32'd1);
    check("mid_addr",     32'(wr_addr[base]),  32'd0);
    check("mid_data",     wr_data[base],       32'hDEAD_BEEF);
    check("mid_done",     32'(done),           32'd1);
    check("mid_cpu_rst",  32'(cpu_rst),        32'd0);

    // ---- Zero-length image -----------------------------------------------
    do_reset();
    base = wr_n;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h00, 1'b1, 8);
`ifdef IMEM_LOADER_CHECKSUM_EN
    c = tb_chk;
    send_byte(c, 1'b1, 8);
`endif
    check("zero_done",    32'(done),         32'd1);
    check("zero_no_we",   32'(wr_n - base),  32'd0);
    check("zero_cpu_rst", 32'(cpu_rst),      32'd0);
    check("zero_err",     32'(err),          32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- Checksum mismatch -----------------------------------------------
    do_reset();
    base = wr_n;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h04, 1'b1, 8);
    c = tb_chk ^ 8'hFF;
    send_byte(c, 1'b1, 8);
    check("chk_err",      32'(err),         32'd1);
    check("chk_done",     32'(done),        32'd0);
    check("chk_cpu_rst",  32'(cpu_rst),     32'd1);
    check("chk_we_count", 32'(wr_n - base), 32'd1);
    check("chk_data",     wr_data[base],    32'h0102_0304);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
